// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared definitions for the external-interrupt controller.
//   gw_state_e : gateway state per source (IDLE / PEND / BUSY)
//   CFG_*      : cfg_sel encodings for the configuration write port
// Optional feature macro: IRQ_CTRL_EDGE_EN (per-source edge mode).
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    GW_IDLE = 2'd0,
    GW_PEND = 2'd1,
    GW_BUSY = 2'd2
  } gw_state_e;

  localparam logic [1:0] CFG_EN     = 2'd0;
  localparam logic [1:0] CFG_EDGE   = 2'd1;
  localparam logic [1:0] CFG_PRIO   = 2'd2;
  localparam logic [1:0] CFG_THRESH = 2'd3;

endpackage

// File: rtl/irq_gateway.sv
// irq_gateway: one interrupt source. A 2-flop synchroniser feeds the
// IDLE/PEND/BUSY gateway FSM.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   src_i         raw asynchronous source line
//   en_i          source enable (registered in the top level)
//   edge_i        edge mode select (only with IRQ_CTRL_EDGE_EN)
//   claim_i       this source is being claimed this cycle
//   complete_i    this source is being completed this cycle
//   pend_o        gateway is in PEND
// Macro IRQ_CTRL_EDGE_EN builds the edge detector and the one-deep
// deferred flag; without it the gateway is level-only.
module irq_gateway
  import irq_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic src_i,
  input  logic en_i,
`ifdef IRQ_CTRL_EDGE_EN
  input  logic edge_i,
`endif
  input  logic claim_i,
  input  logic complete_i,
  output logic pend_o
);

  logic      sync1_q, sync2_q;
  gw_state_e state_q, state_d;
  logic      req;

`ifdef IRQ_CTRL_EDGE_EN
  logic prev_q, deferred_q, deferred_d, rise;
  assign rise = sync2_q & ~prev_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= GW_IDLE;
`ifdef IRQ_CTRL_EDGE_EN
      prev_q     <= 1'b0;
      deferred_q <= 1'b0;
`endif
    end else begin
      sync1_q <= src_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
`ifdef IRQ_CTRL_EDGE_EN
      prev_q     <= sync2_q;
      deferred_q <= deferred_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    req     = sync2_q;
`ifdef IRQ_CTRL_EDGE_EN
    // A stale deferred flag must not survive a switch back to level mode.
    deferred_d = deferred_q & edge_i;
    if (edge_i) req = rise;
`endif
    case (state_q)
      GW_IDLE: begin
        if (req && en_i) state_d = GW_PEND;
      end
      GW_PEND: begin
        // Edges arriving while PEND are absorbed (nothing to do here).
        if (!en_i)        state_d = GW_IDLE;
        else if (claim_i) state_d = GW_BUSY;
      end
      GW_BUSY: begin
        // Disable does not abort an in-service source; only completion does.
        if (complete_i) state_d = GW_IDLE;
`ifdef IRQ_CTRL_EDGE_EN
        if (edge_i) begin
          if (complete_i) begin
            // An edge coinciding with completion counts as deferred too.
            if (deferred_q || rise) state_d = GW_PEND;
            deferred_d = 1'b0;
          end else if (rise) begin
            deferred_d = 1'b1;
          end
        end
`endif
      end
      default: state_d = GW_IDLE;
    endcase
  end

  assign pend_o = (state_q == GW_PEND);

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: parametrised external-interrupt controller with programmable
// priority/threshold and a claim/complete handshake.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   src_irq[NUM_SRC]       raw source lines, bit i is ID i+1
//   cfg_we/sel/idx/wdata   configuration write (enable/edge/prio/threshold)
//   claim_req              claim the current claim_id
//   claim_id               best eligible pending ID, 0 = none
//   complete_req/id        retire an in-service ID
//   ext_irq                interrupt level to the CSR unit
// Macro IRQ_CTRL_EDGE_EN enables per-source edge mode; without it all
// sources are level-triggered and edge-mode writes are dropped.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter  int NUM_SRC = 8,
  parameter  int PRIO_W  = 3,
  localparam int ID_W    = $clog2(NUM_SRC + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [ID_W-1:0]   cfg_idx,
  input  logic [PRIO_W-1:0] cfg_wdata,
  input  logic              claim_req,
  output logic [ID_W-1:0]   claim_id,
  input  logic              complete_req,
  input  logic [ID_W-1:0]   complete_id,
  output logic              ext_irq
);

  logic [NUM_SRC-1:0] en_q, en_d;
  logic [PRIO_W-1:0]  prio_q [NUM_SRC];
  logic [PRIO_W-1:0]  prio_d [NUM_SRC];
  logic [PRIO_W-1:0]  thresh_q, thresh_d;
`ifdef IRQ_CTRL_EDGE_EN
  logic [NUM_SRC-1:0] edge_q, edge_d;
`endif

  logic [NUM_SRC-1:0] pend, elig, claim_vec, complete_vec;
  logic [ID_W-1:0]    best_id;
  logic [PRIO_W-1:0]  best_prio;

  // Configuration registers. Index 0 or out-of-range never matches.
  always_comb begin
    en_d     = en_q;
    prio_d   = prio_q;
    thresh_d = thresh_q;
`ifdef IRQ_CTRL_EDGE_EN
    edge_d   = edge_q;
`endif
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cfg_we && (cfg_idx == ID_W'(i + 1))) begin
        if (cfg_sel == CFG_EN)   en_d[i]   = cfg_wdata[0];
        if (cfg_sel == CFG_PRIO) prio_d[i] = cfg_wdata;
`ifdef IRQ_CTRL_EDGE_EN
        if (cfg_sel == CFG_EDGE) edge_d[i] = cfg_wdata[0];
`endif
      end
    end
    if (cfg_we && (cfg_sel == CFG_THRESH)) thresh_d = cfg_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= '0;
      prio_q   <= '{default: '0};
      thresh_q <= '0;
`ifdef IRQ_CTRL_EDGE_EN
      edge_q   <= '0;
`endif
    end else begin
      en_q     <= en_d;
      prio_q   <= prio_d;
      thresh_q <= thresh_d;
`ifdef IRQ_CTRL_EDGE_EN
      edge_q   <= edge_d;
`endif
    end
  end

  // Per-source gateways plus claim/complete decode. ID 0 and out-of-range
  // IDs match no slot, so those requests fall through with no effect.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign claim_vec[gi]    = claim_req && (claim_id == ID_W'(gi + 1));
    assign complete_vec[gi] = complete_req && (complete_id == ID_W'(gi + 1));
    assign elig[gi]         = pend[gi] && en_q[gi] && (prio_q[gi] > thresh_q);

    irq_gateway u_gw (
      .clk        (clk),
      .rst        (rst),
      .src_i      (src_irq[gi]),
      .en_i       (en_q[gi]),
`ifdef IRQ_CTRL_EDGE_EN
      .edge_i     (edge_q[gi]),
`endif
      .claim_i    (claim_vec[gi]),
      .complete_i (complete_vec[gi]),
      .pend_o     (pend[gi])
    );
  end

  // Max-priority select over registered state only. Strict '>' keeps the
  // lowest ID on ties; priority 0 can never beat threshold >= 0.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (elig[i] && ((best_id == '0) || (prio_q[i] > best_prio))) begin
        best_id   = ID_W'(i + 1);
        best_prio = prio_q[i];
      end
    end
  end

  assign claim_id = best_id;
  assign ext_irq  = (best_id != '0);

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl (default
// parameters). Edge-mode steps are built only with IRQ_CTRL_EDGE_EN.
module tb_irq_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] src_irq;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [3:0] cfg_idx;
  logic [2:0] cfg_wdata;
  logic       claim_req;
  logic [3:0] claim_id;
  logic       complete_req;
  logic [3:0] complete_id;
  logic       ext_irq;

  int total = 0;
  int bad   = 0;

  irq_ctrl #(.NUM_SRC(8), .PRIO_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .src_irq      (src_irq),
    .cfg_we       (cfg_we),
    .cfg_sel      (cfg_sel),
    .cfg_idx      (cfg_idx),
    .cfg_wdata    (cfg_wdata),
    .claim_req    (claim_req),
    .claim_id     (claim_id),
    .complete_req (complete_req),
    .complete_id  (complete_id),
    .ext_irq      (ext_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [3:0] idx, input logic [2:0] d);
    cfg_we = 1'b1; cfg_sel = sel; cfg_idx = idx; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic claim();
    claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
  endtask

  task automatic complete(input logic [3:0] id);
    complete_req = 1'b1; complete_id = id;
    tick();
    complete_req = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      $display("check %s obs=%0d exp=%0d", tag, obs, exp);
    else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; src_irq = '0; cfg_we = 1'b0; cfg_sel = '0; cfg_idx = '0;
    cfg_wdata = '0; claim_req = 1'b0; complete_req = 1'b0; complete_id = '0;
    #1;
    check("rst_ext", ext_irq, 0);
    check("rst_id", claim_id, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("idle_ext", ext_irq, 0);

    // Level path on ID3.
    cfg(2'd0, 4'd3, 3'd1);
    cfg(2'd2, 4'd3, 3'd2);
    src_irq[2] = 1'b1;
    tick(); tick();
    check("lvl_edge2", ext_irq, 0);
    tick();
    check("lvl_edge3_ext", ext_irq, 1);
    check("lvl_edge3_id", claim_id, 3);
    claim();
    check("lvl_claim", ext_irq, 0);
    complete(4'd3);
    check("lvl_cmp", claim_id, 0);
    tick();
    check("lvl_repend", claim_id, 3);
    src_irq[2] = 1'b0;
    claim();
    complete(4'd3);
    tick();
    check("lvl_clear", ext_irq, 0);

    // Priority and ties: ID2=5, ID4=5, ID1=3.
    cfg(2'd0, 4'd2, 3'd1); cfg(2'd2, 4'd2, 3'd5);
    cfg(2'd0, 4'd4, 3'd1); cfg(2'd2, 4'd4, 3'd5);
    cfg(2'd0, 4'd1, 3'd1); cfg(2'd2, 4'd1, 3'd3);
    src_irq = 8'b0000_1011;
    tick(); tick(); tick();
    check("prio_first", claim_id, 2);
    claim();
    check("prio_second", claim_id, 4);
    claim();
    check("prio_third", claim_id, 1);
    claim();
    check("prio_none", claim_id, 0);
    complete(4'd2);
    check("cmp2_idle", claim_id, 0);
    tick();
    check("cmp2_repend", claim_id, 2);
    // Claim ID2 and complete ID4 in the same cycle.
    claim_req = 1'b1; complete_req = 1'b1; complete_id = 4'd4;
    tick();
    claim_req = 1'b0; complete_req = 1'b0;
    check("both_a", claim_id, 0);
    tick();
    check("both_b", claim_id, 4);
    complete(4'd0);
    check("cmp_id0", claim_id, 4);
    complete(4'd5);
    check("cmp_idle_id", claim_id, 4);
    complete(4'd15);
    check("cmp_range", claim_id, 4);
    claim();
    check("still_busy", claim_id, 0);
    src_irq = '0;
    tick(); tick();
    complete(4'd1); complete(4'd2); complete(4'd4);
    tick();
    check("prio_clear", ext_irq, 0);

    // Threshold, disable while pending, priority 0.
    cfg(2'd0, 4'd5, 3'd1);
    cfg(2'd2, 4'd5, 3'd2);
    cfg(2'd3, 4'd0, 3'd2);
    src_irq[4] = 1'b1;
    tick(); tick(); tick(); tick();
    check("thr_block", ext_irq, 0);
    cfg(2'd3, 4'd0, 3'd1);
    check("thr_open_ext", ext_irq, 1);
    check("thr_open_id", claim_id, 5);
    src_irq[4] = 1'b0;
    tick(); tick(); tick();
    check("pend_hold", claim_id, 5);
    cfg(2'd0, 4'd5, 3'd0);
    check("dis_pend", ext_irq, 0);
    cfg(2'd0, 4'd5, 3'd1);
    check("dis_idle", ext_irq, 0);
    cfg(2'd3, 4'd0, 3'd0);
    cfg(2'd2, 4'd5, 3'd0);
    src_irq[4] = 1'b1;
    tick(); tick(); tick();
    check("prio0", ext_irq, 0);
    cfg(2'd2, 4'd5, 3'd2);
    check("prio0_fix", claim_id, 5);

    // Reset while ID3 is BUSY (ID5 still pending at equal priority).
    src_irq[2] = 1'b1;
    tick(); tick(); tick();
    check("tie_35", claim_id, 3);
    claim();
    check("after_claim3", claim_id, 5);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_ext", ext_irq, 0);
    check("rst_mid_id", claim_id, 0);
    tick();
    rst = 1'b0;
    cfg(2'd0, 4'd3, 3'd1);
    cfg(2'd2, 4'd3, 3'd2);
    tick();
    check("rst_repend", claim_id, 3);
    src_irq = '0;
    claim();
    complete(4'd3);
    tick();
    check("rst_clear", ext_irq, 0);

`ifdef IRQ_CTRL_EDGE_EN
    // Edge mode on ID1 with a deferred second pulse.
    cfg(2'd0, 4'd1, 3'd1);
    cfg(2'd1, 4'd1, 3'd1);
    cfg(2'd2, 4'd1, 3'd1);
    src_irq[0] = 1'b1;
    tick();
    src_irq[0] = 1'b0;
    tick(); tick();
    check("edge_pend", claim_id, 1);
    claim();
    check("edge_claim", claim_id, 0);
    src_irq[0] = 1'b1;
    tick();
    src_irq[0] = 1'b0;
    tick(); tick(); tick();
    check("edge_deferred", claim_id, 0);
    complete(4'd1);
    check("edge_after_cmp", claim_id, 1);
    claim();
    complete(4'd1);
    tick();
    check("edge_clear", ext_irq, 0);
`else
    // Edge-mode write is dropped: ID1 keeps level behaviour and re-pends.
    cfg(2'd1, 4'd1, 3'd1);
    cfg(2'd0, 4'd1, 3'd1);
    cfg(2'd2, 4'd1, 3'd1);
    src_irq[0] = 1'b1;
    tick(); tick(); tick();
    check("lvl1_pend", claim_id, 1);
    claim();
    complete(4'd1);
    tick();
    check("lvl1_repend", claim_id, 1);
    src_irq = '0;
    claim();
    complete(4'd1);
    tick();
    check("lvl1_clear", ext_irq, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Parametrised external-interrupt controller that replaces the single raw `ei` line into the CSR unit. It collects `NUM_SRC` interrupt sources, gates each through a pending/in-service tracker, and arbitrates by programmable priority. It drives one `ext_irq` level into the CSR unit, and the trap handler uses a claim/complete handshake to identify and retire each source.

## Interface
- `NUM_SRC`, 8: number of sources; IDs run 1..NUM_SRC, and ID 0 means "none".
- `PRIO_W`, 3: priority/threshold width.
- `ID_W`: local parameter equal to `$clog2(NUM_SRC+1)`; not overridable.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `src_irq` in NUM_SRC: raw asynchronous source lines; bit i is ID i+1.
- `cfg_we` in 1: configuration write strobe.
- `cfg_sel` in 2: 0 = enable, 1 = edge mode, 2 = priority, 3 = threshold.
- `cfg_idx` in ID_W: target source ID; ignored for threshold; ID 0 or >NUM_SRC is ignored.
- `cfg_wdata` in PRIO_W: write data; bit 0 is used for enable and edge mode.
- `claim_req` in 1: one-cycle claim strobe.
- `claim_id` out ID_W: highest-priority eligible pending ID, or 0.
- `complete_req` in 1: one-cycle completion strobe.
- `complete_id` in ID_W: ID being completed.
- `ext_irq` out 1: interrupt request to the CSR unit.

## Operation
- Each source passes through a 2-flop synchroniser and then a gateway FSM with three states: IDLE, PEND, BUSY.
- Level mode transitions:
  - IDLE→PEND when synced input = 1 and enable = 1.
  - PEND→IDLE if enable is cleared.
  - PEND→BUSY on a claim of this ID.
  - BUSY→IDLE on a completion of this ID.
  - A line still high after completion re-pends on the next cycle.
- Edge mode transitions:
  - A rising edge (synced input, compared against the previous synced value) takes an enabled IDLE source to PEND.
  - A rising edge while PEND is absorbed.
  - A rising edge while BUSY sets a one-deep `deferred` flag.
  - Completion with `deferred` set goes BUSY→PEND and clears `deferred`.
- Eligibility: a source is eligible when it is PEND, enabled, and its priority > threshold. Priority 0 is never eligible.
- `claim_id` is the eligible source with the maximum priority; ties go to the lowest ID. It is 0 if no source is eligible.
- `ext_irq` = (`claim_id` != 0).
- Both `claim_id` and `ext_irq` are functions of registered state only; no input has a combinational path to them.
- `claim_req` applies to the current `claim_id`. A claim while `claim_id` = 0 has no effect.
- `complete_req` for an ID that is not BUSY, or is out of range, has no effect.
- Claim and complete in the same cycle both apply; they necessarily target different states.
- Disabling a BUSY source leaves it BUSY until it is completed.
- Configuration writes take effect at the clock edge and influence arbitration from the next cycle onward.
- Reset clears all of the following to 0, and all gateways go to IDLE:
  - synchronisers, previous-input registers, `deferred` flags
  - enables, edge bits, priorities, threshold
  - outputs `ext_irq` = 0 and `claim_id` = 0.
- Reset asserted mid-operation aborts every in-service source; no completion is needed afterwards.

## Timing
- Source latency: if `src_irq` is first sampled high at edge 0, the synchroniser output is high after edge 1, PEND is set after edge 2, and `ext_irq`/`claim_id` are valid in that same cycle. The lowest-to-output latency is therefore 3 clock edges.
- Claim at edge N: the source is BUSY after edge N, and `ext_irq`/`claim_id` reflect the next candidate in cycle N+1.
- Complete at edge N: the source is IDLE or PEND after edge N. A still-asserted level source re-pends after edge N+1.
- Arbitration is a single-cycle combinational tree over NUM_SRC entries.

## Configuration
- Macro: `IRQ_CTRL_EDGE_EN`.
- Defined: per-source edge mode is available, along with the edge-detect registers and the `deferred` flags.
- Undefined:
  - All sources are level mode, and the edge-detect logic is not built.
  - `cfg_sel` = 1 writes are ignored.

## Structure
- Package `irq_ctrl_pkg` holds:
  - the gateway state enum (IDLE/PEND/BUSY)
  - the `cfg_sel` encodings (`CFG_EN`, `CFG_EDGE`, `CFG_PRIO`, `CFG_THRESH`).
- Sub-module `irq_gateway` contains one source's synchroniser, FSM, edge detect and `deferred` flag. It is instantiated NUM_SRC times by a generate loop.
- The top level holds the configuration registers, the arbiter, and the claim/complete decode.

## Test plan
- Level path: set ID3 with enable = 1 and priority = 2, threshold 0; raise `src_irq[2]`. Expect `ext_irq` = 1 and `claim_id` = 3 on the 3rd edge. Claim → `ext_irq` = 0 the next cycle. Complete with the line still high → re-pend, `claim_id` = 3 again.
- Priority and ties: ID2 at priority 5, ID4 at priority 5, ID1 at priority 3, all asserted. Expect `claim_id` = 2, then 4 after claiming 2, then 1 after claiming 4.
- Threshold: ID5 at priority 2 asserted with threshold 2 → `ext_irq` = 0. Write threshold 1 → `ext_irq` = 1 the next cycle.
- Edge deferral (`IRQ_CTRL_EDGE_EN`): ID1 in edge mode; pulse, claim, then pulse again while BUSY. Expect `claim_id` = 0 until completion, then `claim_id` = 1 in the cycle after completion.
- Robustness:
  - Completing an IDLE ID, or completing ID 0, changes no state.
  - Claim and complete in the same cycle both apply.
  - `rst` asserted while ID3 is BUSY → all outputs 0 immediately, and re-assertion is accepted without a completion.
